// File: rtl/priority_encoder.sv
// priority_encoder: registered WIDTH-to-$clog2(WIDTH) priority encoder.
// The highest-numbered set bit of `in` wins. `out` and `valid` are registered
// and appear one clock after sampling. `valid` is the only way to tell
// "bit 0 set" apart from "nothing set".
// Optional feature macro: PRIORITY_ENCODER_ONEHOT_EN adds a registered
// one-hot grant output `onehot`.
module priority_encoder #(
  parameter  int WIDTH = 8,
  localparam int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  output logic [WIDTH-1:0] onehot,
`endif
  output logic             valid
);

  // Leading-one search. Higher indices overwrite lower ones, so the highest
  // set bit wins. An all-zero vector yields index 0.
  function automatic logic [OUT_W-1:0] encode_msb(input logic [WIDTH-1:0] vec);
    logic [OUT_W-1:0] idx;
    idx = {OUT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      idx = vec[i] ? OUT_W'(i) : idx;
    end
    return idx;
  endfunction

  logic [OUT_W-1:0] out_s;
  logic             valid_s;
  logic [OUT_W-1:0] out_r;
  logic             valid_r;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [WIDTH-1:0] onehot_s;
  logic [WIDTH-1:0] onehot_r;
`endif

  // Combinational encode of the current request vector.
  always_comb begin
    out_s   = encode_msb(in);
    valid_s = |in;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    onehot_s = {WIDTH{1'b0}};
    if (valid_s) begin
      onehot_s = {{(WIDTH-1){1'b0}}, 1'b1} << out_s;
    end else begin
      onehot_s = {WIDTH{1'b0}};
    end
`endif
  end

  // Output registers. Reset clears them asynchronously, so no stale result
  // survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r    <= {OUT_W{1'b0}};
      valid_r  <= 1'b0;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      onehot_r <= {WIDTH{1'b0}};
`endif
    end else begin
      out_r    <= out_s;
      valid_r  <= valid_s;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      onehot_r <= onehot_s;
`endif
    end
  end

  assign out   = out_r;
  assign valid = valid_r;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  assign onehot = onehot_r;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder (WIDTH = 8).
// Expected results are pushed to a scoreboard queue when stimulus is driven.
// They are popped and compared one cycle later.
module tb_priority_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in  = 8'h00;
  logic [2:0] out;
  logic       valid;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [7:0] onehot;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] o;
    logic       v;
    logic [7:0] oh;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  priority_encoder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .out   (out),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    .onehot(onehot),
`endif
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Reference model: scan downward from the MSB and stop at the first set bit.
  function automatic exp_t model(input logic [7:0] v);
    exp_t r;
    r.o  = 3'd0;
    r.v  = 1'b0;
    r.oh = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r.o  = 3'(i);
        r.v  = 1'b1;
        r.oh = 8'h00;
        r.oh[i] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    // Power-on reset: hold for two edges.
    rst = 1'b1;
    in  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in  = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (out !== 3'd7 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: out=%0d valid=%0b expected out=7 valid=1", out, valid);
    end
    // Assert reset mid-cycle. The outputs must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out !== 3'd0) begin
      errors++;
      $display("FAIL reset_async_out: out=%0d expected 0", out);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_valid: valid=%0b expected 0", valid);
    end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    checks++;
    if (onehot !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_onehot: onehot=%b expected 0", onehot);
    end
`endif
    // Hold reset through two edges with in=FF.
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 3'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out=%0d valid=%0b expected out=0 valid=0", out, valid);
    end
    // Release reset. The first edge with reset low produces a fresh result.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 3'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_pre_edge: out=%0d valid=%0b expected out=0 valid=0", out, valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out !== 3'd7 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_first: out=%0d valid=%0b expected out=7 valid=1", out, valid);
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    in = 8'h00;
    sb.push_back(model(in));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (out !== e.o || valid !== e.v) begin
      errors++;
      $display("FAIL zero: out=%0d valid=%0b expected out=%0d valid=%0b", out, valid, e.o, e.v);
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in = 8'h01 << i;
      sb.push_back(model(in));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out !== e.o || valid !== e.v || out !== 3'(i)) begin
        errors++;
        $display("FAIL walk[%0d]: out=%0d valid=%0b expected out=%0d valid=1", i, out, valid, i);
      end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      checks++;
      if (onehot !== e.oh) begin
        errors++;
        $display("FAIL walk_onehot[%0d]: onehot=%b expected %b", i, onehot, e.oh);
      end
`endif
    end
  endtask

  task automatic test_multihot();
    logic [7:0] vecs [4];
    logic [2:0] want [4];
    vecs[0] = 8'b00100101; want[0] = 3'd5;
    vecs[1] = 8'b11111111; want[1] = 3'd7;
    vecs[2] = 8'b00000011; want[2] = 3'd1;
    vecs[3] = 8'b10000001; want[3] = 3'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in = vecs[i];
      sb.push_back(model(in));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out !== want[i] || out !== e.o || valid !== 1'b1) begin
        errors++;
        $display("FAIL multihot[%0d]: out=%0d valid=%0b expected out=%0d valid=1", i, out, valid, want[i]);
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    in = 8'h01;
    @(posedge clk); #1;
    checks++;
    if (out !== 3'd0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL glitch_first: out=%0d valid=%0b expected out=0 valid=1", out, valid);
    end
    // Change the input between edges. The registered outputs must hold.
    #2 in = 8'h80;
    #2;
    checks++;
    if (out !== 3'd0) begin
      errors++;
      $display("FAIL glitch_hold: out=%0d expected 0", out);
    end
    @(posedge clk); #1;
    checks++;
    if (out !== 3'd7 || valid !== 1'b1) begin
      errors++;
      $display("FAIL glitch_next: out=%0d valid=%0b expected out=7 valid=1", out, valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      in = (i % 6 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      sb.push_back(model(in));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out !== e.o || valid !== e.v) begin
        errors++;
        $display("FAIL b2b[%0d]: out=%0d valid=%0b expected out=%0d valid=%0b", i, out, valid, e.o, e.v);
      end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      checks++;
      if (onehot !== e.oh) begin
        errors++;
        $display("FAIL b2b_onehot[%0d]: onehot=%b expected %b", i, onehot, e.oh);
      end
`endif
    end
  endtask

`ifdef PRIORITY_ENCODER_ONEHOT_EN
  task automatic test_onehot();
    @(negedge clk);
    in = 8'b01010000;
    @(posedge clk); #1;
    checks++;
    if (out !== 3'd6 || onehot !== 8'b01000000) begin
      errors++;
      $display("FAIL onehot_sel: out=%0d onehot=%b expected out=6 onehot=01000000", out, onehot);
    end
    @(negedge clk);
    in = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (onehot !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL onehot_zero: onehot=%b valid=%0b expected onehot=0 valid=0", onehot, valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_walk();
    test_multihot();
    test_glitch();
    test_back_to_back();
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    test_onehot();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder.md
# priority_encoder

Registered 8-to-3 priority encoder: reports the index of the highest-numbered asserted bit of an 8-bit request vector, one clock after sampling. Used wherever a one-hot or multi-hot request vector must become a binary index (interrupt selection, arbitration front end, leading-one detection). Output is fully registered, so it can drive downstream logic without adding combinational depth.

## Interface
Parameters:
- WIDTH, 8, request vector width; must be a power of two, ≥2.
- OUT_W, $clog2(WIDTH) = 3, index width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  request vector; bit i set means request i active.
- out  output  OUT_W  binary index of highest set bit of `in`; registered.
- valid  output  1  high when at least one bit of `in` was set; registered.
- onehot  output  WIDTH  one-hot grant, present only with PRIORITY_ENCODER_ONEHOT_EN.

## Operation
- Priority: MSB highest. `out` = largest i with `in[i]`=1; lower set bits ignored.
- Exactly one bit set: `out` = position of that bit (8'b00000001→0, 8'b10000000→7).
- Multiple bits set: highest wins (8'b00100101→5).
- `in`=0: `out`=0, `valid`=0. `valid` is the only way to distinguish "bit 0 set" from "nothing set".
- `valid` = OR-reduction of `in`, registered alongside `out`.
- No internal state beyond the output registers; each cycle independent of history.
- `in` treated as synchronous to clk; no synchronizers inside.
- X/Z on `in` not handled; caller guarantees known values.

## Timing
- Latency: exactly 1 cycle. `in` sampled at rising edge N appears on `out`/`valid` after edge N; stable until edge N+1.
- Throughput: one new encode per cycle, no stalls, no handshake.
- Reset: `rst` high immediately (asynchronously) forces `out`=0, `valid`=0, `onehot`=0, independent of clk.
- Reset mid-operation: any in-flight result discarded; first valid result is from first rising edge with `rst` low.
- Reset release: deassertion takes effect at the next rising edge; no stale data appears.
- Input change between edges has no effect on outputs until the next edge.

## Configuration
- Macro: PRIORITY_ENCODER_ONEHOT_EN.
- Defined: extra output port `onehot[WIDTH-1:0]`, registered with same 1-cycle latency; exactly the winning bit set (`onehot` = 1 << `out` when `valid`=1), all zeros when `valid`=0; reset value 0.
- Not defined: port `onehot` and its register absent; `out`/`valid` behaviour unchanged.

## Test plan
- Reset: assert `rst` with `in`=8'hFF mid-cycle → `out`=0, `valid`=0 immediately, no clock needed; hold through two edges, still 0.
- Zero input: `in`=8'b00000000 after reset → `out`=0, `valid`=0 after next edge.
- One-hot walk: drive 8'b00000001, 8'b00000010, … 8'b10000000 on successive cycles → `out` = 0,1,…,7 with `valid`=1, each one cycle after its input.
- Multi-hot priority: 8'b00100101→5, 8'b11111111→7, 8'b00000011→1, 8'b10000001→7, all `valid`=1.
- Latency/glitch: change `in` from 8'h01 to 8'h80 between edges → `out` stays 0 until next rising edge, then 7.
- With PRIORITY_ENCODER_ONEHOT_EN: `in`=8'b01010000 → `out`=6, `onehot`=8'b01000000; `in`=0 → `onehot`=0.
